// File: rtl/datapath_unit.sv
// Execution datapath: ALU, data memory and registered result mux, driven each
// cycle by the control unit. No handshake; one operation per clock.
module datapath_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign alu_a    = operand1;
  assign alu_b    = sel3 ? offset : operand2;
  assign sum_wide = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result = sum_wide[DATA_WIDTH-1:0];
        alu_carry  = sum_wide[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOT:  alu_result = ~alu_a;
      OP_SLL:  alu_result = alu_a << alu_b[2:0];
      OP_SRL:  alu_result = alu_a >> alu_b[2:0];
      OP_INC:  alu_result = alu_a + 1'b1;
      OP_DEC:  alu_result = alu_a - 1'b1;
      OP_PASS: alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  // Address wraps by truncating the ALU result.
  assign addr    = alu_result[ADDR_BITS-1:0];
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_WIDTH'(i);
      end
    end else if (w_r) begin
      mem[addr] <= operand2;
    end
  end

  // rd_data is sampled before the same-edge write lands, so a colliding read
  // returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      result2 <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      result2 <= sel1 ? alu_result : rd_data;
      if (sel1 && (opcode != OP_NOP)) begin
        zero  <= (alu_result == '0);
        carry <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboarded bench for datapath_unit: directed cases followed by random
// traffic, each checked against an arithmetic reference model.
module tb_datapath_unit;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int M  = 1 << DW;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] operand1 = '0;
  logic [DW-1:0] operand2 = '0;
  logic [DW-1:0] offset = '0;
  logic [3:0]    opcode = '0;
  logic          sel1 = 1'b0;
  logic          sel3 = 1'b0;
  logic          w_r = 1'b0;
  logic [DW-1:0] result2;
  logic          zero;
  logic          carry;

  datapath_unit #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2),
    .offset(offset), .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .result2(result2), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  // Expected entry packs {result2, zero, carry}.
  logic [DW+1:0] exp_q[$];
  int mem_m [D];
  int zero_m = 0;
  int carry_m = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int r, output int c);
    r = 0;
    c = 0;
    case (op)
      0:  begin r = (a + b) % M; c = (a + b >= M); end
      1:  begin r = (a - b + M) % M; c = (a < b); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = M - 1 - a;
      6:  r = (a * (2 ** (b % 8))) % M;
      7:  r = a / (2 ** (b % 8));
      8:  r = (a + 1) % M;
      9:  r = (a + M - 1) % M;
      10: r = b;
      default: r = 0;
    endcase
  endfunction

  task automatic step(input bit r_i, input int op1, input int op2, input int off,
                      input int opc, input bit s1, input bit s3, input bit wr);
    int res, c, addr, exp_r;
    @(negedge clk);
    rst = r_i; operand1 = DW'(op1); operand2 = DW'(op2); offset = DW'(off);
    opcode = 4'(opc); sel1 = s1; sel3 = s3; w_r = wr;
    if (r_i) begin
      for (int i = 0; i < D; i++) mem_m[i] = i % M;
      zero_m = 0; carry_m = 0; exp_r = 0;
    end else begin
      alu_ref(opc, op1, s3 ? off : op2, res, c);
      addr  = res % D;
      exp_r = s1 ? res : mem_m[addr];
      if (s1 && opc != 15) begin
        zero_m = (res == 0); carry_m = c;
      end
      if (wr) mem_m[addr] = op2;
    end
    exp_q.push_back({DW'(exp_r), zero_m[0], carry_m[0]});
  endtask

  // Monitor: one result per edge for every issued operation.
  initial begin
    logic [DW+1:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (result2 !== e[DW+1:2]) begin
          errors++;
          $display("FAIL result2 t=%0t got=%h exp=%h", $time, result2, e[DW+1:2]);
        end
        if (zero !== e[1]) begin
          errors++;
          $display("FAIL zero t=%0t got=%b exp=%b", $time, zero, e[1]);
        end
        if (carry !== e[0]) begin
          errors++;
          $display("FAIL carry t=%0t got=%b exp=%b", $time, carry, e[0]);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 3, 0, 0, 1, 0);          // mem[5] = 5
    step(0, 200, 100, 0, 0, 1, 0, 0);      // 44, carry
    step(0, 5, 5, 0, 1, 1, 0, 0);          // 0, zero
    step(0, 1, 'hA5, 4, 0, 0, 1, 1);       // old word 5
    step(0, 1, 'hA5, 4, 0, 0, 1, 0);       // new word A5
    step(0, 30, 0, 5, 0, 0, 1, 0);         // wrap to address 3
    step(0, 200, 100, 0, 0, 1, 0, 0);
    step(0, 9, 9, 0, 15, 1, 0, 0);         // NOP keeps flags
    step(0, 9, 9, 0, 11, 1, 0, 0);         // undefined code yields 0
    step(0, 3, 'hA5, 4, 1, 1, 0, 0);       // set carry via borrow
    step(1, 1, 'h77, 4, 0, 0, 1, 1);       // write ignored under reset
    step(0, 1, 0, 4, 0, 0, 1, 0);          // mem[5] back to 5
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 40),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 2) == 0);
    end
    repeat (3) @(negedge clk);
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution datapath that sits on the far side of the control unit's operand/control bus: it consumes `operand1`, `operand2`, `offset`, `opcode`, `sel1`, `sel3` and `w_r` every clock and returns `result2` for write-back. It contains the ALU, a 2^ADDR_BITS × DATA_WIDTH data memory and the registered result mux. It carries no FSM of its own; the control unit sequences it cycle by cycle.

## Interface
- `DATA_WIDTH`, default 8: width of operands, memory words and result.
- `ADDR_BITS`, default 5: data memory address width (32 words).
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `operand1` input, DATA_WIDTH: ALU A input; base address for loads and stores.
- `operand2` input, DATA_WIDTH: ALU B input when `sel3=0`; store data.
- `offset` input, DATA_WIDTH: ALU B input when `sel3=1`.
- `opcode` input, 4 bits: ALU operation.
- `sel1` input, 1 bit: result source; 1 = ALU, 0 = memory read data.
- `sel3` input, 1 bit: ALU B source; 0 = `operand2`, 1 = `offset`.
- `w_r` input, 1 bit: memory write enable.
- `result2` output, DATA_WIDTH: registered result returned to the control unit.
- `zero` output, 1 bit: registered ALU zero flag.
- `carry` output, 1 bit: registered ALU carry/borrow flag.

## Operation
- B = `sel3` ? `offset` : `operand2`; A = `operand1`.
- ALU (combinational, DATA_WIDTH-bit result, truncated):
  - 0000 ADD A+B; carry = bit DATA_WIDTH of the sum.
  - 0001 SUB A−B; carry = borrow (A<B unsigned).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A.
  - 0110 SLL A by B[2:0]; 0111 SRL A by B[2:0].
  - 1000 INC A, 1001 DEC A, 1010 PASS B.
  - 1111 NOP: result 0.
  - Every other code also yields result 0.
  - carry = 0 for all opcodes except ADD and SUB.
- Memory address = low ADDR_BITS of the ALU result. Wrap-around is by truncation, e.g. 30+5 → address 3.
- Memory read is combinational from the current address.
- Write: if `w_r=1` and `rst=0`, mem[addr] <= `operand2` at the rising edge.
- Result register: each edge, `result2` <= `sel1` ? ALU result : mem[addr].
- Flags: update only when `sel1=1` and `opcode`≠1111.
  - `zero` <= (ALU result == 0).
  - `carry` <= ALU carry.
  - Otherwise both flags hold their value.
- Read-during-write to the same address in one cycle: `result2` captures the old word. The new word is visible from the next cycle.
- Reset (synchronous, takes priority over everything):
  - `result2`=0, `zero`=0, `carry`=0.
  - mem[i] <= i (truncated to DATA_WIDTH) for every i.
  - A `w_r=1` in a reset cycle is ignored.

## Timing
- Inputs are sampled at the rising edge.
- `result2`, `zero` and `carry` are valid 1 cycle after the inputs are presented.
- A write takes effect at the edge where `w_r=1`; a read of that address returns the new data from the following cycle.
- The control unit holds inputs stable across EXECUTE → MEM_ACCESS → WRITE_BACK. Because of that, `result2` is stable by WRITE_BACK regardless of which cycle first presented the inputs.
- No handshake; throughput is one operation per cycle.

## Test plan
- Reset, then `sel1=0 sel3=1 opcode=0000 operand1=2 offset=3` → next cycle `result2=5` (initial mem[5]=5).
- `sel1=1 sel3=0 opcode=0000 operand1=200 operand2=100` → `result2=44`, `carry=1`, `zero=0`. Follow with SUB 5−5 → `result2=0`, `zero=1`, `carry=0`.
- Store with `w_r=1 sel1=0 sel3=1 opcode=0000 operand1=1 offset=4 operand2=0xA5` → same-edge `result2=5` (old data). Next cycle with `w_r=0` and the same inputs → `result2=0xA5`.
- Wrap: `operand1=30 offset=5` ADD, `sel1=0` → reads address 3, `result2=3`.
- `opcode=1111 sel1=1` after a flag-setting op → `result2=0`, `zero`/`carry` unchanged. `opcode=1011` → `result2=0`.
- Assert `rst` with `w_r=1` targeting an address previously written to 0xA5 → that word reads back its index, `result2=0` and flags are 0 after the edge.
